// File: rtl/usbh_hid_report_mux.sv
// usbh_hid_report_mux
// Captures HID reports from several usbh_host_hid ports, tracks per-port
// liveness with a timeout, and selects one report (fixed by sel or following
// the most recently changed port) for the hex/OLED display path.
// Everything runs in the clk_usb domain.
module usbh_hid_report_mux #(
    parameter int C_channels      = 3,
    parameter int C_report_length = 20,
    parameter int C_out_bytes     = 8,
    parameter int C_sel_bits      = 2,
    parameter int C_timeout_bits  = 22
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [C_channels*C_report_length*8-1:0]  hid_report,
    input  logic [C_channels-1:0]                    hid_valid,
    input  logic                                     mode,
    input  logic [C_sel_bits-1:0]                    sel,
    output logic [C_out_bytes*8-1:0]                 out_report,
    output logic [C_sel_bits-1:0]                    out_channel,
    output logic                                     out_valid,
    output logic [C_channels-1:0]                    alive,
    output logic [C_channels-1:0]                    changed
);

    localparam int RW = C_report_length * 8;
    localparam int OW = C_out_bytes * 8;

    // Timer saturates at all-ones; the port expires on the step that reaches it,
    // so a port stays alive for 2**C_timeout_bits-1 cycles after its last report.
    localparam logic [C_timeout_bits-1:0] TIMER_MAX  = {C_timeout_bits{1'b1}};
    localparam logic [C_timeout_bits-1:0] TIMER_ONE  = C_timeout_bits'(1'b1);
    localparam logic [C_timeout_bits-1:0] TIMER_EXP  = TIMER_MAX - TIMER_ONE;
    localparam logic [C_timeout_bits-1:0] TIMER_ZERO = {C_timeout_bits{1'b0}};
    localparam logic [C_sel_bits:0]       NUM_CH     = (C_sel_bits + 1)'(C_channels);
    localparam logic [C_sel_bits-1:0]     SEL_ZERO   = {C_sel_bits{1'b0}};

    // Per-port state
    logic [RW-1:0]             report_buf_r [C_channels];
    logic [C_timeout_bits-1:0] timer_r      [C_channels];
    logic [C_channels-1:0]     alive_r;
    logic [C_channels-1:0]     changed_r;
    logic [C_channels-1:0]     expired_r;

    // Selection / output state
    logic [C_sel_bits-1:0]     auto_sel_r;
    logic [OW-1:0]             out_report_r;
    logic [C_sel_bits-1:0]     out_channel_r;
    logic                      out_valid_r;

    // Combinational helpers
    logic [RW-1:0]             port_report_s [C_channels];
    logic [C_channels-1:0]     diff_s;
    logic [C_channels-1:0]     expire_s;
    logic [C_sel_bits-1:0]     first_changed_s;
    logic [C_sel_bits-1:0]     target_s;
    logic [OW-1:0]             sel_report_s;
    logic                      target_expired_s;
    logic                      out_valid_s;

    // Slice the flat report bus per port and decode capture-difference and expiry
    always_comb begin
        for (int i = 0; i < C_channels; i++) begin
            port_report_s[i] = hid_report[i*RW +: RW];
            diff_s[i]        = hid_valid[i] & (port_report_s[i] != report_buf_r[i]);
            // A strobe in the expiry cycle wins over the timeout
            expire_s[i]      = alive_r[i] & ~hid_valid[i] & (timer_r[i] == TIMER_EXP);
        end
    end

    // Per-port report buffer, liveness timer, alive flag and change/expiry pulses
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < C_channels; i++) begin
                report_buf_r[i] <= {RW{1'b0}};
                timer_r[i]      <= TIMER_ZERO;
            end
            alive_r   <= {C_channels{1'b0}};
            changed_r <= {C_channels{1'b0}};
            expired_r <= {C_channels{1'b0}};
        end else begin
            for (int i = 0; i < C_channels; i++) begin
                if (hid_valid[i]) begin
                    report_buf_r[i] <= port_report_s[i];
                    timer_r[i]      <= TIMER_ZERO;
                    alive_r[i]      <= 1'b1;
                end else if (expire_s[i]) begin
                    report_buf_r[i] <= {RW{1'b0}};
                    timer_r[i]      <= TIMER_MAX;
                    alive_r[i]      <= 1'b0;
                end else if (alive_r[i]) begin
                    timer_r[i]      <= (timer_r[i] == TIMER_MAX) ? TIMER_MAX : timer_r[i] + TIMER_ONE;
                end else begin
                    timer_r[i]      <= timer_r[i];
                end
            end
            changed_r <= diff_s;
            expired_r <= expire_s;
        end
    end

    // Lowest port with a change pulse this cycle, else the remembered auto choice
    always_comb begin
        first_changed_s = auto_sel_r;
        for (int i = C_channels - 1; i >= 0; i--) begin
            first_changed_s = changed_r[i] ? C_sel_bits'(i) : first_changed_s;
        end
    end

    // Display target: auto follows the last change, fixed mode clamps out-of-range sel to port 0
    always_comb begin
        target_s = SEL_ZERO;
        if (mode) begin
            target_s = first_changed_s;
        end else if ({1'b0, sel} >= NUM_CH) begin
            target_s = SEL_ZERO;
        end else begin
            target_s = sel;
        end
    end

    // Fetch the low bytes of the target buffer and whether it was just timed out
    always_comb begin
        sel_report_s     = {OW{1'b0}};
        target_expired_s = 1'b0;
        for (int i = 0; i < C_channels; i++) begin
            sel_report_s     = (target_s == C_sel_bits'(i)) ? report_buf_r[i][OW-1:0] : sel_report_s;
            target_expired_s = (target_s == C_sel_bits'(i)) ? expired_r[i] : target_expired_s;
        end
        out_valid_s = (target_s != out_channel_r) | (sel_report_s != out_report_r) | target_expired_s;
    end

    // Output register stage and auto-select latch (latch only tracks while in auto mode)
    always_ff @(posedge clk) begin
        if (!rstn) begin
            auto_sel_r    <= SEL_ZERO;
            out_report_r  <= {OW{1'b0}};
            out_channel_r <= SEL_ZERO;
            out_valid_r   <= 1'b0;
        end else begin
            auto_sel_r    <= mode ? first_changed_s : auto_sel_r;
            out_report_r  <= sel_report_s;
            out_channel_r <= target_s;
            out_valid_r   <= out_valid_s;
        end
    end

    assign out_report  = out_report_r;
    assign out_channel = out_channel_r;
    assign out_valid   = out_valid_r;
    assign alive       = alive_r;
    assign changed     = changed_r;

endmodule

// File: tb/tb_usbh_hid_report_mux.sv
// Self-checking bench for usbh_hid_report_mux: expected values are queued with
// the cycle they are due when stimulus is driven, and compared at negedge.
module tb_usbh_hid_report_mux;

    localparam int CH = 3;
    localparam int RL = 20;
    localparam int OB = 8;
    localparam int SB = 2;
    localparam int TO = 4;
    localparam int RW = RL * 8;
    localparam int OW = OB * 8;

    localparam int K_REPORT  = 0;
    localparam int K_CHANNEL = 1;
    localparam int K_VALID   = 2;
    localparam int K_ALIVE   = 3;
    localparam int K_CHANGED = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [CH*RW-1:0]  hid_report;
    logic [CH-1:0]     hid_valid;
    logic              mode;
    logic [SB-1:0]     sel;
    logic [OW-1:0]     out_report;
    logic [SB-1:0]     out_channel;
    logic              out_valid;
    logic [CH-1:0]     alive;
    logic [CH-1:0]     changed;

    usbh_hid_report_mux #(
        .C_channels      (CH),
        .C_report_length (RL),
        .C_out_bytes     (OB),
        .C_sel_bits      (SB),
        .C_timeout_bits  (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .hid_report  (hid_report),
        .hid_valid   (hid_valid),
        .mode        (mode),
        .sel         (sel),
        .out_report  (out_report),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .alive       (alive),
        .changed     (changed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard, kept as parallel queues
    int          due_q  [$];
    int          kind_q [$];
    string       tag_q  [$];
    logic [63:0] exp_q  [$];

    logic [RW-1:0] rep [CH];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_at(input int due, input int kind, input string tag, input logic [63:0] v);
        due_q.push_back(due);
        kind_q.push_back(kind);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            K_REPORT:  return out_report;
            K_CHANNEL: return {62'd0, out_channel};
            K_VALID:   return {63'd0, out_valid};
            K_ALIVE:   return {61'd0, alive};
            K_CHANGED: return {61'd0, changed};
            default:   return {64{1'b1}};
        endcase
    endfunction

    // Compare every queued expectation that falls due in this cycle
    always @(negedge clk) begin
        int idx;
        idx = 0;
        while (idx < due_q.size()) begin
            if (due_q[idx] == cyc) begin
                check_val(tag_q[idx], observe(kind_q[idx]), exp_q[idx]);
                due_q.delete(idx);
                kind_q.delete(idx);
                tag_q.delete(idx);
                exp_q.delete(idx);
            end else begin
                idx++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        hid_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_strobe(input logic [CH-1:0] mask);
        for (int i = 0; i < CH; i++) hid_report[i*RW +: RW] = rep[i];
        hid_valid = mask;
        tick();
    endtask

    task automatic randomize_bus();
        for (int k = 0; k < CH*RW/32; k++) hid_report[k*32 +: 32] = $urandom();
        hid_valid = 3'($urandom_range(0, 7));
    endtask

    initial begin
        int t;
        for (int i = 0; i < CH; i++) rep[i] = '0;
        rstn = 1'b0;
        mode = 1'b0;
        sel  = 2'd0;
        randomize_bus();

        // 1: reset held two cycles with random strobes
        tick();
        randomize_bus();
        tick();
        t = cyc;
        rstn = 1'b1;
        sel  = 2'd1;
        expect_at(t, K_REPORT,  "rst_report",  64'd0);
        expect_at(t, K_CHANNEL, "rst_channel", 64'd0);
        expect_at(t, K_VALID,   "rst_valid",   64'd0);
        expect_at(t, K_ALIVE,   "rst_alive",   64'd0);
        expect_at(t, K_CHANGED, "rst_changed", 64'd0);
        expect_at(t + 1, K_CHANNEL, "sel_to_ch1", 64'd1);
        expect_at(t + 1, K_VALID,   "sel_valid",  64'd1);
        idle(2);

        // 2: fixed mode, port 1, then an identical repeat
        rep[1][7:0] = 8'h5A;
        t = cyc;
        expect_at(t + 1, K_CHANGED, "m0_changed",  64'b010);
        expect_at(t + 1, K_ALIVE,   "m0_alive",    64'b010);
        expect_at(t + 1, K_VALID,   "m0_valid_t1", 64'd0);
        expect_at(t + 2, K_REPORT,  "m0_report",   64'h5A);
        expect_at(t + 2, K_VALID,   "m0_valid_t2", 64'd1);
        expect_at(t + 2, K_CHANNEL, "m0_channel",  64'd1);
        drive_strobe(3'b010);
        t = cyc;
        expect_at(t + 1, K_CHANGED, "rep_changed",  64'd0);
        expect_at(t + 2, K_VALID,   "rep_valid",    64'd0);
        expect_at(t + 2, K_REPORT,  "rep_report",   64'h5A);
        drive_strobe(3'b010);
        idle(20);

        // 3: auto mode, simultaneous change picks lowest, then follows port 2
        mode = 1'b1;
        expect_at(cyc + 1, K_CHANNEL, "auto_init_ch", 64'd0);
        tick();
        rep[0] = '0; rep[0][7:0] = 8'h22;
        rep[2] = '0; rep[2][7:0] = 8'h11;
        t = cyc;
        expect_at(t + 1, K_CHANGED, "auto_changed2", 64'b101);
        expect_at(t + 2, K_CHANNEL, "auto_lowest",   64'd0);
        expect_at(t + 2, K_REPORT,  "auto_rep22",    64'h22);
        expect_at(t + 2, K_VALID,   "auto_valid22",  64'd1);
        drive_strobe(3'b101);
        rep[2][7:0] = 8'h33;
        t = cyc;
        expect_at(t + 1, K_CHANGED, "auto_changed1", 64'b100);
        expect_at(t + 2, K_CHANNEL, "auto_ch2",      64'd2);
        expect_at(t + 2, K_REPORT,  "auto_rep33",    64'h33);
        expect_at(t + 3, K_CHANNEL, "auto_hold",     64'd2);
        expect_at(t + 3, K_VALID,   "auto_quiet",    64'd0);
        drive_strobe(3'b100);
        idle(2);
        mode = 1'b0;
        sel  = 2'd0;
        t = cyc;
        expect_at(t + 1, K_CHANNEL, "sw_m0_ch",  64'd0);
        expect_at(t + 1, K_REPORT,  "sw_m0_rep", 64'h22);
        expect_at(t + 2, K_CHANNEL, "sw_m1_ch",  64'd2);
        expect_at(t + 2, K_REPORT,  "sw_m1_rep", 64'h33);
        tick();
        mode = 1'b1;
        tick();
        mode = 1'b0;
        idle(20);

        // 4: timeout of the shown port, then a strobe on the expiry cycle
        rep[0] = '0; rep[0][7:0] = 8'h77;
        t = cyc;
        expect_at(t + 1,  K_CHANGED, "to_changed",   64'b001);
        expect_at(t + 15, K_ALIVE,   "to_alive_end", 64'b001);
        expect_at(t + 16, K_ALIVE,   "to_dead",      64'b000);
        expect_at(t + 16, K_CHANGED, "to_nochg",     64'd0);
        expect_at(t + 16, K_REPORT,  "to_rep_hold",  64'h77);
        expect_at(t + 17, K_REPORT,  "to_rep_clr",   64'd0);
        expect_at(t + 17, K_VALID,   "to_valid",     64'd1);
        drive_strobe(3'b001);
        idle(17);
        t = cyc;
        expect_at(t + 1,  K_CHANGED, "exp_first_chg", 64'b001);
        expect_at(t + 16, K_ALIVE,   "exp_alive",     64'b001);
        expect_at(t + 16, K_CHANGED, "exp_nochg",     64'd0);
        expect_at(t + 17, K_REPORT,  "exp_rep",       64'h77);
        expect_at(t + 17, K_VALID,   "exp_novalid",   64'd0);
        expect_at(t + 30, K_ALIVE,   "exp_alive2",    64'b001);
        expect_at(t + 31, K_ALIVE,   "exp_dead2",     64'b000);
        drive_strobe(3'b001);
        idle(14);
        drive_strobe(3'b001);
        idle(20);

        // 5: out-of-range sel falls back to port 0; change beyond output bytes
        sel = 2'd2;
        t = cyc;
        expect_at(t + 1, K_CHANNEL, "sel2_ch",   64'd2);
        expect_at(t + 2, K_CHANNEL, "sel3_ch",   64'd0);
        expect_at(t + 2, K_VALID,   "sel3_vld",  64'd1);
        tick();
        sel = 2'd3;
        tick();
        rep[0] = '0; rep[0][7:0] = 8'hA5; rep[0][103:96] = 8'h01;
        t = cyc;
        expect_at(t + 2, K_REPORT, "b12_base",  64'hA5);
        expect_at(t + 2, K_VALID,  "b12_bvld",  64'd1);
        drive_strobe(3'b001);
        tick();
        rep[0][103:96] = 8'hFE;
        t = cyc;
        expect_at(t + 1, K_CHANGED, "b12_changed", 64'b001);
        expect_at(t + 1, K_VALID,   "b12_vld1",    64'd0);
        expect_at(t + 2, K_VALID,   "b12_vld2",    64'd0);
        expect_at(t + 2, K_REPORT,  "b12_report",  64'hA5);
        expect_at(t + 2, K_CHANNEL, "b12_channel", 64'd0);
        drive_strobe(3'b001);
        idle(20);

        // 6: one-cycle reset mid-stream on live ports
        sel = 2'd1;
        tick();
        rep[0] = '0; rep[0][7:0] = 8'h01;
        rep[1] = '0; rep[1][7:0] = 8'hB1;
        rep[2] = '0; rep[2][7:0] = 8'h02;
        t = cyc;
        expect_at(t + 1, K_ALIVE,  "mid_alive",  64'b111);
        expect_at(t + 2, K_REPORT, "mid_report", 64'hB1);
        drive_strobe(3'b111);
        tick();
        rstn = 1'b0;
        expect_at(t + 3, K_ALIVE,   "mr_alive",   64'd0);
        expect_at(t + 3, K_REPORT,  "mr_report",  64'd0);
        expect_at(t + 3, K_CHANNEL, "mr_channel", 64'd0);
        expect_at(t + 3, K_VALID,   "mr_valid",   64'd0);
        expect_at(t + 3, K_CHANGED, "mr_changed", 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        t = cyc;
        expect_at(t + 1, K_CHANGED, "resume_chg",   64'b010);
        expect_at(t + 1, K_ALIVE,   "resume_alive", 64'b010);
        expect_at(t + 2, K_REPORT,  "resume_rep",   64'hB1);
        drive_strobe(3'b010);
        idle(4);

        check_val("sb_pending", 64'(due_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
